estagio_execucao: RTL and testbench

- Execute-stage sequencer between instruction decode and register-file writeback.
- Accepts one decoded operation through a valid/ready handshake, registers it, and drives the combinational `alu` through its A/B/operacao ports.
- Waits a fixed extra latency for long operations (mul/div/mod), captures the ALU result and flags, and offers them to writeback through a second valid/ready handshake.
- Owns the architectural status (flags) register.

---
 rtl/estagio_execucao.sv | 108 ++++++++++
 tb/tb_estagio_execucao.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_execucao.sv
// Execute stage: latches one decoded operation, drives the external ALU, waits
// out long-op latency and hands the result and flags to writeback.
module estagio_execucao #(
  parameter int LAT_LONGA  = 4,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  descarta,
  input  logic                  ent_valido,
  output logic                  ent_pronto,
  input  logic [3:0]            ent_operacao,
  input  logic [7:0]            ent_A,
  input  logic [7:0]            ent_B,
  input  logic [REG_ADDR_W-1:0] ent_destino,
  input  logic                  ent_grava_flags,
  output logic [7:0]            alu_A,
  output logic [7:0]            alu_B,
  output logic [3:0]            alu_operacao,
  input  logic [7:0]            alu_resultado,
  input  logic [7:0]            alu_flags,
  output logic                  sai_valido,
  input  logic                  sai_pronto,
  output logic [7:0]            sai_resultado,
  output logic [REG_ADDR_W-1:0] sai_destino,
  output logic [7:0]            sai_flags,
  output logic [7:0]            status,
  output logic                  ocupado
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, ENTREGA} estado_t;

  localparam logic [3:0] CARGA_LONGA = 4'(LAT_LONGA - 1);

  estado_t               estado;
  logic [3:0]            contador;
  logic [REG_ADDR_W-1:0] destino_q;
  logic                  grava_flags_q;
  logic                  aceita;
  logic                  carry_valido;
  logic [7:0]            flags_mascaradas;

  function automatic logic op_longa(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
  endfunction

  assign ent_pronto = !rst && !descarta &&
                      ((estado == OCIOSO) || ((estado == ENTREGA) && sai_pronto));
  assign aceita     = ent_valido && ent_pronto;
  assign sai_valido = (estado == ENTREGA);
  assign ocupado    = (estado != OCIOSO);

  // Only add and subtract produce a meaningful carry; anything else is stale.
  assign carry_valido     = (alu_operacao == 4'b0000) || (alu_operacao == 4'b0001);
  assign flags_mascaradas = {alu_flags[7:6], alu_flags[5] & carry_valido, alu_flags[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= OCIOSO;
      contador      <= '0;
      destino_q     <= '0;
      grava_flags_q <= 1'b0;
      alu_A         <= '0;
      alu_B         <= '0;
      alu_operacao  <= '0;
      sai_resultado <= '0;
      sai_destino   <= '0;
      sai_flags     <= '0;
      status        <= '0;
    end else if (descarta) begin
      estado   <= OCIOSO;
      contador <= '0;
    end else begin
      case (estado)
        OCIOSO: ;
        EXECUTA: begin
          if (contador != 4'd0) begin
            contador <= contador - 4'd1;
          end else begin
            sai_resultado <= alu_resultado;
            sai_destino   <= destino_q;
            sai_flags     <= flags_mascaradas;
            estado        <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (sai_pronto) begin
            if (grava_flags_q) status <= sai_flags;
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase

      // Acceptance overrides the ENTREGA->OCIOSO move so back-to-back ops chain.
      if (aceita) begin
        alu_operacao  <= ent_operacao;
        alu_A         <= ent_A;
        alu_B         <= ent_B;
        destino_q     <= ent_destino;
        grava_flags_q <= ent_grava_flags;
        contador      <= op_longa(ent_operacao) ? CARGA_LONGA : 4'd0;
        estado        <= EXECUTA;
      end
    end
  end

endmodule

// File: tb/tb_estagio_execucao.sv
// Bench for estagio_execucao: a behavioural ALU plus a transaction-level model of
// the stage, compared every cycle, with directed scenarios and random traffic.
module tb_estagio_execucao;

  localparam int LAT = 4;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          descarta = 1'b0;
  logic          ent_valido = 1'b0;
  logic          ent_pronto;
  logic [3:0]    ent_operacao = '0;
  logic [7:0]    ent_A = '0;
  logic [7:0]    ent_B = '0;
  logic [AW-1:0] ent_destino = '0;
  logic          ent_grava_flags = 1'b0;
  logic [7:0]    alu_A, alu_B;
  logic [3:0]    alu_operacao;
  logic [7:0]    alu_resultado, alu_flags;
  logic          sai_valido;
  logic          sai_pronto = 1'b0;
  logic [7:0]    sai_resultado;
  logic [AW-1:0] sai_destino;
  logic [7:0]    sai_flags;
  logic [7:0]    status;
  logic          ocupado;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  estagio_execucao #(.LAT_LONGA(LAT), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .descarta(descarta),
    .ent_valido(ent_valido), .ent_pronto(ent_pronto), .ent_operacao(ent_operacao),
    .ent_A(ent_A), .ent_B(ent_B), .ent_destino(ent_destino), .ent_grava_flags(ent_grava_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_operacao(alu_operacao),
    .alu_resultado(alu_resultado), .alu_flags(alu_flags),
    .sai_valido(sai_valido), .sai_pronto(sai_pronto), .sai_resultado(sai_resultado),
    .sai_destino(sai_destino), .sai_flags(sai_flags), .status(status), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {flags, result}; non add/sub ops report a junk carry of 1.
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, v;
    c = 1'b1; v = 1'b0; r = 8'h00;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: r = a << 1;
      4'h7: r = a >> 1;
      4'h8: begin p = a * b; r = p[7:0]; end
      4'h9: r = (b == 0) ? 8'h00 : a / b;
      4'hA: r = (b == 0) ? 8'h00 : a % b;
      4'hB: r = a + 8'h01;
      default: r = 8'h00;
    endcase
    return {r[7], (r == 8'h00), c, ^r, 1'b0, 1'b0, v, 1'b0, r};
  endfunction

  // What writeback must see for an op: ALU output with C cleared unless add/sub.
  function automatic logic [15:0] esperado(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x;
    x = alu_ref(op, a, b);
    if (op != 4'h0 && op != 4'h1) x[13] = 1'b0;
    return x;
  endfunction

  always_comb {alu_flags, alu_resultado} = alu_ref(alu_operacao, alu_A, alu_B);

  // Transaction model: one pending op, edges remaining until its result is offered.
  logic          m_busy, m_ov, m_gf, o_gf;
  int            m_rem;
  logic [3:0]    m_op;
  logic [7:0]    m_a, m_b, o_res, o_flags, m_status;
  logic [AW-1:0] m_dest, o_dest;

  always @(posedge clk or posedge rst) begin
    logic prn, acc;
    logic [15:0] x;
    if (rst) begin
      m_busy = 0; m_ov = 0; m_rem = 0; m_status = 0;
      m_op = 0; m_a = 0; m_b = 0; m_dest = 0; m_gf = 0;
    end else begin
      prn = !descarta && (!m_busy || (m_ov && sai_pronto));
      acc = ent_valido && prn;
      if (descarta) begin
        m_busy = 0; m_ov = 0;
      end else begin
        if (m_ov && sai_pronto) begin
          if (o_gf) m_status = o_flags;
          m_ov = 0; m_busy = 0;
        end else if (m_busy && !m_ov) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            x = esperado(m_op, m_a, m_b);
            o_res = x[7:0]; o_flags = x[15:8]; o_dest = m_dest; o_gf = m_gf;
            m_ov = 1;
          end
        end
        if (acc) begin
          m_op = ent_operacao; m_a = ent_A; m_b = ent_B; m_dest = ent_destino; m_gf = ent_grava_flags;
          m_busy = 1;
          m_rem = (ent_operacao inside {4'h8, 4'h9, 4'hA}) ? LAT : 1;
        end
      end
    end
  end

  task automatic checkOutput(input string nome, input logic [15:0] atual, input logic [15:0] req);
    n_vec++;
    if (atual !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        checkOutput("rst ent_pronto", 16'(ent_pronto), 16'h0);
        checkOutput("rst sai_valido", 16'(sai_valido), 16'h0);
        checkOutput("rst status", 16'(status), 16'h0);
        checkOutput("rst alu", {alu_A, alu_B}, 16'h0);
      end else begin
        checkOutput("ent_pronto", 16'(ent_pronto),
                    16'(!descarta && (!m_busy || (m_ov && sai_pronto))));
        checkOutput("sai_valido", 16'(sai_valido), 16'(m_ov));
        checkOutput("ocupado", 16'(ocupado), 16'(m_busy));
        checkOutput("status", 16'(status), 16'(m_status));
        if (m_ov) begin
          checkOutput("sai_resultado", 16'(sai_resultado), 16'(o_res));
          checkOutput("sai_destino", 16'(sai_destino), 16'(o_dest));
          checkOutput("sai_flags", 16'(sai_flags), 16'(o_flags));
        end
        if (m_busy) begin
          checkOutput("alu_AB", {alu_A, alu_B}, {m_a, m_b});
          checkOutput("alu_operacao", 16'(alu_operacao), 16'(m_op));
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [AW-1:0] d, input logic gf, input logic pr, input logic ds);
    ent_valido = v; ent_operacao = op; ent_A = a; ent_B = b;
    ent_destino = d; ent_grava_flags = gf; sai_pronto = pr; descarta = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts an op on the next edge and returns edges (acceptance edge included) to sai_valido.
  task automatic runOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic gf, output int edges);
    applyStimulus(1, op, a, b, 3'd5, gf, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    edges = 1;
    for (int i = 0; i < 20 && !sai_valido; i++) begin
      if (ent_pronto) checkOutput("ent_pronto while busy", 16'(ent_pronto), 16'h0);
      tick();
      edges++;
    end
    if (!sai_valido) checkOutput("sai_valido timeout", 16'(sai_valido), 16'h1);
  endtask

  initial begin
    int e;
    #2 rst = 1'b1;
    chk_on = 1'b1;
    #1;
    checkOutput("reset sai_flags", 16'(sai_flags), 16'h0);
    checkOutput("reset ent_pronto", 16'(ent_pronto), 16'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("after reset ent_pronto", 16'(ent_pronto), 16'h1);
    checkOutput("after reset status", 16'(status), 16'h0);

    runOp(4'h0, 8'h7F, 8'h01, 1, e);
    checkOutput("add latency", 16'(e), 16'd2);
    checkOutput("add result", 16'(sai_resultado), 16'h80);
    checkOutput("add flags", 16'(sai_flags), 16'h92);
    sai_pronto = 1; tick(); sai_pronto = 0;
    checkOutput("add status", 16'(status), 16'h92);

    runOp(4'h1, 8'h05, 8'h05, 1, e);
    checkOutput("sub result", 16'(sai_resultado), 16'h00);
    checkOutput("sub flags", 16'(sai_flags), 16'h40);
    sai_pronto = 1; tick();
    checkOutput("sub status", 16'(status), 16'h40);

    // AND with grava_flags=0 while a second op waits behind a stalled writeback.
    applyStimulus(1, 4'h2, 8'hF0, 8'h0F, 3'd1, 0, 0, 0);
    tick();
    applyStimulus(1, 4'h4, 8'hAA, 8'h0F, 3'd2, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall sai_valido", 16'(sai_valido), 16'h1);
      checkOutput("stall ent_pronto", 16'(ent_pronto), 16'h0);
      checkOutput("stall flags", 16'(sai_flags), 16'h40);
      checkOutput("stall destino", 16'(sai_destino), 16'd1);
      tick();
    end
    sai_pronto = 1; #1;
    checkOutput("release ent_pronto", 16'(ent_pronto), 16'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("and status kept", 16'(status), 16'h40);
    tick();
    checkOutput("chained valid", 16'(sai_valido), 16'h1);
    checkOutput("chained result", 16'(sai_resultado), 16'hA5);
    tick();

    runOp(4'h8, 8'h10, 8'h10, 1, e);
    checkOutput("mul latency", 16'(e), 16'(LAT + 1));
    checkOutput("mul result", 16'(sai_resultado), 16'h00);
    checkOutput("mul flags", 16'(sai_flags), 16'h40);
    sai_pronto = 1; tick(); sai_pronto = 0;

    runOp(4'h0, 8'h7F, 8'h01, 1, e);
    sai_pronto = 1; tick();
    checkOutput("status before flush", 16'(status), 16'h92);
    applyStimulus(1, 4'h9, 8'h40, 8'h03, 3'd4, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    descarta = 1; #1;
    checkOutput("flush ent_pronto", 16'(ent_pronto), 16'h0);
    tick();
    descarta = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("flushed sai_valido", 16'(sai_valido), 16'h0);
      checkOutput("flushed status", 16'(status), 16'h92);
      tick();
    end
    runOp(4'hC, 8'h12, 8'h34, 0, e);
    checkOutput("unlisted flags", 16'(sai_flags), 16'h40);
    sai_pronto = 1; tick();

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom), 8'($urandom),
                    AW'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 39) == 0));
      tick();
    end

    applyStimulus(1, 4'hA, 8'h33, 8'h05, 3'd6, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst ent_pronto", 16'(ent_pronto), 16'h0);
    checkOutput("async rst ocupado", 16'(ocupado), 16'h0);
    checkOutput("async rst alu_operacao", 16'(alu_operacao), 16'h0);
    checkOutput("async rst status", 16'(status), 16'h0);
    #3 rst = 1'b0;
    #1;
    checkOutput("post rst ent_pronto", 16'(ent_pronto), 16'h1);
    checkOutput("post rst status", 16'(status), 16'h0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
